// File: rtl/dsp_adc_sample_source.sv
// -----------------------------------------------------------------------------
// dsp_adc_sample_source
//
// Sample-producing front end for the Goertzel magnitude path. A free-running
// tick counter paces conversions from an external 8-bit SPI ADC. Each frame
// is shifted in over SPI (SCLK idles high, MISO sampled on SCLK rising).
// Each finished frame is published as a one-cycle adc_data_ready strobe.
// adc_data_in holds that sample until the next strobe. The first
// WARMUP_FRAMES conversions after enable are dummies. adc_rdy tells the DSP
// that the stream is now valid.
//
// Build option:
//   DSP_ADC_TWOS_COMP_EN  defined   -> the MSB of each sample is inverted
//                                      (offset binary -> two's complement)
//                         undefined -> the sample is published as unsigned
//
// Ports:
//   sys_clk         in   system clock, rising edge
//   sys_rst         in   asynchronous active-high reset
//   enable          in   run conversions
//   adc_miso        in   ADC serial data, MSB first
//   adc_cs_n        out  ADC chip select, active low
//   adc_sclk        out  SPI clock, idle high
//   adc_data_ready  out  one-cycle strobe, new sample on adc_data_in
//   adc_data_in     out  last published sample (B_W bits)
//   adc_rdy         out  warm-up complete, sample stream valid
//   sample_overrun  out  sticky, a tick arrived while a frame was running
// -----------------------------------------------------------------------------
module dsp_adc_sample_source #(
  parameter int B_W           = 8,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_BITS     = 3,
  parameter int SCLK_DIV      = 4,
  parameter int SAMPLE_DIV    = 400,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           enable,
  input  logic           adc_miso,
  output logic           adc_cs_n,
  output logic           adc_sclk,
  output logic           adc_data_ready,
  output logic [B_W-1:0] adc_data_in,
  output logic           adc_rdy,
  output logic           sample_overrun
);

  // ---------------------------------------------------------------------------
  // Counter widths. Each width is at least 1 bit, so degenerate parameter
  // values (SCLK_DIV=1, WARMUP_FRAMES=0) still give legal vectors.
  // ---------------------------------------------------------------------------
  localparam int TICK_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DIV_W  = $clog2(SCLK_DIV + 1);
  localparam int BIT_W  = $clog2(FRAME_BITS + 1);
  localparam int WARM_W = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [WARM_W-1:0] WARM_FULL = WARM_W'(WARMUP_FRAMES);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

  // The capture window is a constant mask that bit_cnt indexes. The mask
  // covers every value bit_cnt can encode, so the lookup can never go out of
  // range.
  localparam int BIT_SPAN = 1 << BIT_W;

`ifdef DSP_ADC_TWOS_COMP_EN
  localparam bit TWOS_COMP = 1'b1;
`else
  localparam bit TWOS_COMP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    DONE
  } state_t;

  state_t              state_reg;
  logic [TICK_W-1:0]   tick_cnt_reg;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [WARM_W-1:0]   warm_cnt_reg;
  logic [B_W-1:0]      shift_reg;
  logic                frame_live_reg;   // this frame is published when it ends
  logic                cs_n_reg;
  logic                sclk_reg;
  logic                ready_reg;
  logic [B_W-1:0]      data_reg;
  logic                rdy_reg;
  logic                overrun_reg;

  logic                tick;
  logic                in_window;
  logic [BIT_SPAN-1:0] capture_mask;
  logic [B_W-1:0]      pub_val;

  // ---------------------------------------------------------------------------
  // Constant capture mask: bit gi is set when rising edge number gi+1 carries
  // a data bit (after the LEAD_BITS leading bits, for B_W bits).
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < BIT_SPAN; gi++) begin : g_capture_mask
    assign capture_mask[gi] = (gi >= LEAD_BITS) && (gi < LEAD_BITS + B_W);
  end

  assign in_window = capture_mask[bit_cnt_reg];

  // ---------------------------------------------------------------------------
  // Publication format. When the build option is on, only the top bit is
  // flipped; that is the whole offset-binary to two's-complement mapping.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < B_W; gi++) begin : g_pub_val
    if ((gi == B_W - 1) && TWOS_COMP) begin : g_flip
      assign pub_val[gi] = ~shift_reg[gi];
    end else begin : g_pass
      assign pub_val[gi] = shift_reg[gi];
    end
  end

  // A tick fires on the SAMPLE_DIV-th consecutive enabled cycle.
  assign tick = enable && (tick_cnt_reg == TICK_LAST);

  // ---------------------------------------------------------------------------
  // Sequencer: tick pacing, SPI frame FSM, warm-up tracking and status flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      div_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      warm_cnt_reg   <= '0;
      shift_reg      <= '0;
      frame_live_reg <= 1'b0;
      cs_n_reg       <= 1'b1;
      sclk_reg       <= 1'b1;
      ready_reg      <= 1'b0;
      data_reg       <= '0;
      rdy_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      ready_reg <= 1'b0;

      // Tick pacing. Dropping enable restarts the interval, so the first tick
      // after enable always comes a full SAMPLE_DIV cycles later.
      if (!enable || (tick_cnt_reg == TICK_LAST)) begin
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end

      // A tick seen outside IDLE (including the DONE cycle) is lost.
      if (tick && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (tick) begin
            cs_n_reg       <= 1'b0;
            div_cnt_reg    <= '0;
            bit_cnt_reg    <= '0;
            // Publication is decided when the frame starts. Then a frame
            // already in flight still completes if enable drops, which
            // clears the warm-up count.
            frame_live_reg <= (warm_cnt_reg == WARM_FULL);
            state_reg      <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            sclk_reg    <= 1'b0;
            state_reg   <= SHIFT;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
            if (!sclk_reg) begin
              // Low-to-high SCLK: the ADC has had a full half-period to
              // settle MISO, so this is the sampling point.
              sclk_reg    <= 1'b1;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (in_window) begin
                shift_reg <= {shift_reg[B_W-2:0], adc_miso};
              end
              if (bit_cnt_reg == BIT_LAST) begin
                state_reg <= DONE;
              end
            end else begin
              sclk_reg <= 1'b0;
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        DONE: begin
          cs_n_reg  <= 1'b1;
          state_reg <= IDLE;
          if (frame_live_reg) begin
            data_reg  <= pub_val;
            ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Warm-up tracking. Only dummy frames that end while enable is high
      // count. adc_rdy rises together with the last dummy frame's DONE.
      if (!enable) begin
        warm_cnt_reg <= '0;
        rdy_reg      <= 1'b0;
      end else if (WARMUP_FRAMES == 0) begin
        rdy_reg <= 1'b1;
      end else if ((state_reg == DONE) && !frame_live_reg &&
                   (warm_cnt_reg != WARM_FULL)) begin
        warm_cnt_reg <= warm_cnt_reg + 1'b1;
        if (warm_cnt_reg == WARM_LAST) begin
          rdy_reg <= 1'b1;
        end
      end
    end
  end

  assign adc_cs_n       = cs_n_reg;
  assign adc_sclk       = sclk_reg;
  assign adc_data_ready = ready_reg;
  assign adc_data_in    = data_reg;
  assign adc_rdy        = rdy_reg;
  assign sample_overrun = overrun_reg;

endmodule

// File: tb/tb_dsp_adc_sample_source.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dsp_adc_sample_source.
// Instance "dut" uses the default parameters. A behavioural model tracks the
// frames and computes every output each cycle from the timing rules.
// Instance "dut_ovr" uses SAMPLE_DIV=100 to exercise the overrun behaviour.
// -----------------------------------------------------------------------------
module tb_dsp_adc_sample_source;

  localparam int B_W        = 8;
  localparam int FB         = 16;
  localparam int D          = 4;
  localparam int S          = 400;
  localparam int W          = 2;
  localparam int FRAME_LEN  = 2 * FB * D;     // 128: last rising SCLK offset
  localparam int FRAME_END  = FRAME_LEN + 1;  // 129: strobe / CS high offset

`ifdef DSP_ADC_TWOS_COMP_EN
  localparam logic [7:0] EXP_B3 = 8'h33;
  localparam logic [7:0] EXP_00 = 8'h80;
`else
  localparam logic [7:0] EXP_B3 = 8'hB3;
  localparam logic [7:0] EXP_00 = 8'h00;
`endif

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic       enable   = 1'b0;
  logic       adc_miso = 1'b0;
  logic       adc_cs_n, adc_sclk, adc_data_ready, adc_rdy, sample_overrun;
  logic [7:0] adc_data_in;

  logic       rst_b    = 1'b1;
  logic       enable_b = 1'b0;
  logic       miso_b   = 1'b0;
  logic       cs_n_b, sclk_b, ready_b, rdy_b, ovr_b;
  logic [7:0] data_b;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  dsp_adc_sample_source #(
    .B_W(8), .FRAME_BITS(16), .LEAD_BITS(3), .SCLK_DIV(4),
    .SAMPLE_DIV(400), .WARMUP_FRAMES(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .adc_miso(adc_miso),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_data_ready(adc_data_ready),
    .adc_data_in(adc_data_in), .adc_rdy(adc_rdy), .sample_overrun(sample_overrun)
  );

  dsp_adc_sample_source #(
    .B_W(8), .FRAME_BITS(16), .LEAD_BITS(3), .SCLK_DIV(4),
    .SAMPLE_DIV(100), .WARMUP_FRAMES(2)
  ) dut_ovr (
    .sys_clk(sys_clk), .sys_rst(rst_b), .enable(enable_b), .adc_miso(miso_b),
    .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .adc_data_ready(ready_b),
    .adc_data_in(data_b), .adc_rdy(rdy_b), .sample_overrun(ovr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef DSP_ADC_TWOS_COMP_EN
    return b ^ 8'h80;
`else
    return b;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: frames are described by their start cycle; every
  // output is a function of the offset into the current frame.
  // ---------------------------------------------------------------------------
  int         m_cyc = 0, m_en_cnt = 0, m_e0 = 0, m_warm = 0;
  bit         m_busy = 0, m_pub = 0, m_ready = 0, m_rdy = 0, m_ovr = 0;
  bit         m_tick = 0, m_was_busy = 0, m_ending = 0;
  logic [7:0] m_byte = 8'h00, m_data = 8'h00;
  bit         force_en = 1'b0;
  logic [7:0] force_val = 8'h00;

  initial forever begin
    @(posedge sys_clk or posedge sys_rst);
    if (sys_rst) begin
      m_en_cnt = 0; m_busy = 0; m_warm = 0; m_data = 8'h00;
      m_ready = 0; m_rdy = 0; m_ovr = 0;
    end else begin
      m_cyc++;
      m_ready = 0;
      m_tick = enable && (((m_en_cnt + 1) % S) == 0);
      m_en_cnt = enable ? m_en_cnt + 1 : 0;
      m_was_busy = m_busy;
      m_ending = m_busy && ((m_cyc - m_e0) == FRAME_END);
      if (m_tick) begin
        if (m_was_busy) m_ovr = 1;
        else begin
          m_busy = 1;
          m_e0 = m_cyc;
          m_pub = (m_warm == W);
          m_byte = force_en ? force_val : 8'($urandom);
        end
      end
      if (m_ending) begin
        m_busy = 0;
        if (m_pub) begin
          m_data = xform(m_byte);
          m_ready = 1;
        end else if (enable && m_warm < W) begin
          m_warm++;
        end
      end
      if (!enable) m_warm = 0;
      m_rdy = enable && (m_warm == W);
    end
  end

  // ADC model: drives each frame bit after an SCLK falling edge. The lead and
  // tail bits are random, so capture-window errors show up in the data.
  int          adc_idx = 0;
  logic [15:0] adc_word = 16'h0;
  logic [31:0] adc_junk = 32'h0;

  initial forever begin
    @(negedge adc_cs_n);
    adc_idx = 0;
    while (adc_idx < FB) begin
      @(negedge adc_sclk or posedge adc_cs_n);
      if (adc_cs_n) break;
      if (adc_idx == 0) begin
        adc_junk = $urandom;
        adc_word = {adc_junk[2:0], m_byte, adc_junk[7:3]};
      end
      adc_miso = adc_word[FB-1-adc_idx];
      adc_idx++;
    end
  end

  // Per-cycle comparison of every output against the model.
  int  c_off;
  bit  e_cs, e_sclk;
  initial forever begin
    @(negedge sys_clk);
    c_off  = m_cyc - m_e0;
    e_cs   = !(m_busy && c_off <= FRAME_LEN);
    e_sclk = !(m_busy && c_off >= D && c_off < FRAME_LEN && ((c_off / D) % 2 == 1));
    checks++;
    if ({adc_cs_n, adc_sclk, adc_data_ready, adc_data_in, adc_rdy, sample_overrun} !==
        {e_cs, e_sclk, m_ready, m_data, m_rdy, m_ovr}) begin
      errors++;
      $display("FAIL cycle_outputs @%0t: got cs_n=%b sclk=%b strobe=%b data=%h rdy=%b ovr=%b, expected cs_n=%b sclk=%b strobe=%b data=%h rdy=%b ovr=%b",
               $time, adc_cs_n, adc_sclk, adc_data_ready, adc_data_in, adc_rdy, sample_overrun,
               e_cs, e_sclk, m_ready, m_data, m_rdy, m_ovr);
    end
  end

  // Event monitor for the literal timing checks.
  int mon_cyc = 0, cs_falls = 0, strobes = 0, last_fall = 0, last_strobe = 0, strobe_gap = 0;
  bit prev_cs_n = 1'b1;
  initial forever begin
    @(negedge sys_clk);
    mon_cyc++;
    if (prev_cs_n && !adc_cs_n) begin
      cs_falls++;
      last_fall = mon_cyc;
    end
    if (adc_data_ready) begin
      strobe_gap = mon_cyc - last_strobe;
      last_strobe = mon_cyc;
      strobes++;
    end
    prev_cs_n = adc_cs_n;
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_strobe(input string name, input int budget);
    int s0 = strobes;
    int n = 0;
    while (strobes == s0 && n < budget) begin step(); n++; end
    check(name, 32'(strobes != s0), 32'd1);
  endtask

  task automatic wait_fall(input string name, input int budget);
    int f0 = cs_falls;
    int n = 0;
    while (cs_falls == f0 && n < budget) begin step(); n++; end
    check(name, 32'(cs_falls != f0), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Overrun instance: SAMPLE_DIV=100 against a 130-cycle frame.
  // ---------------------------------------------------------------------------
  bit ovr_done = 1'b0;
  int ob_falls = 0, ob_rises = 0, ob_last = 0;
  bit ob_prev = 1'b1;
  initial begin
    repeat (2) @(negedge sys_clk);
    rst_b = 1'b0;
    enable_b = 1'b1;
    for (int c = 0; c < 850; c++) begin
      @(negedge sys_clk);
      #1;
      if (ob_prev && !cs_n_b) begin
        ob_falls++;
        if (ob_falls == 1) check("ovr_clear_at_first_frame", 32'(ovr_b), 32'd0);
        else check("ovr_sample_period", 32'(c - ob_last), 32'd200);
        ob_last = c;
      end
      if (!ob_prev && cs_n_b) begin
        ob_rises++;
        if (ob_rises == 1) check("ovr_set_after_first_frame", 32'(ovr_b), 32'd1);
      end
      ob_prev = cs_n_b;
    end
    check("ovr_frame_count", 32'(ob_falls), 32'd4);
    check("ovr_sticky", 32'(ovr_b), 32'd1);
    ovr_done = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int s_mark, f_mark, guard;
  initial begin
    force_en  = 1'b1;
    force_val = 8'hB3;
    repeat (3) step();
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_ready", 32'(adc_data_ready), 32'd0);
    check("rst_data", 32'(adc_data_in), 32'd0);
    check("rst_rdy", 32'(adc_rdy), 32'd0);
    check("rst_overrun", 32'(sample_overrun), 32'd0);
    sys_rst = 1'b0;
    repeat (40) step();
    check("idle_no_frames", 32'(cs_falls), 32'd0);
    check("idle_cs_n", 32'(adc_cs_n), 32'd1);

    // Default frame: two warm-up frames, then 8'hB3 is published.
    enable = 1'b1;
    wait_strobe("first_strobe_arrives", 3 * S + 200);
    check("first_pub_frame_number", 32'(cs_falls), 32'd3);
    check("first_pub_data", 32'(adc_data_in), 32'(EXP_B3));
    check("first_pub_latency", 32'(last_strobe - last_fall), 32'd129);
    check("first_pub_rdy", 32'(adc_rdy), 32'd1);
    step();
    check("strobe_one_cycle", 32'(adc_data_ready), 32'd0);

    force_val = 8'h00;
    wait_strobe("zero_strobe_arrives", S + 50);
    check("zero_pub_data", 32'(adc_data_in), 32'(EXP_00));
    force_en = 1'b0;

    // Rate: ten consecutive samples with random data.
    for (int i = 0; i < 10; i++) begin
      wait_strobe("rate_strobe_arrives", S + 50);
      check("rate_gap", 32'(strobe_gap), 32'd400);
    end
    check("rate_no_overrun", 32'(sample_overrun), 32'd0);

    // Enable drops mid-frame: that frame is still published.
    wait_fall("drop_frame_starts", S + 50);
    repeat (50) step();
    enable = 1'b0;
    f_mark = cs_falls;
    wait_strobe("drop_frame_published", 150);
    check("drop_rdy_low", 32'(adc_rdy), 32'd0);
    repeat (2 * S) step();
    check("drop_no_more_frames", 32'(cs_falls), 32'(f_mark));

    // Reset inside the 8th SCLK period of a publishing frame.
    enable = 1'b1;
    guard = 0;
    while (!adc_rdy && guard < 3 * S + 200) begin step(); guard++; end
    check("rerun_rdy", 32'(adc_rdy), 32'd1);
    wait_fall("rst_frame_starts", S + 50);
    repeat (62) step();
    check("pre_rst_sclk_low", 32'(adc_sclk), 32'd0);
    #2 sys_rst = 1'b1;
    #1;
    check("async_rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("async_rst_sclk", 32'(adc_sclk), 32'd1);
    s_mark = strobes;
    repeat (3) step();
    sys_rst = 1'b0;
    enable = 1'b0;
    repeat (150) step();
    check("rst_no_strobe", 32'(strobes), 32'(s_mark));
    check("rst_rdy_low", 32'(adc_rdy), 32'd0);

    // Random enable bursts, checked cycle by cycle against the model.
    for (int i = 0; i < 8; i++) begin
      enable = 1'b1;
      repeat ($urandom_range(200, 1600)) step();
      enable = 1'b0;
      repeat ($urandom_range(1, 40)) step();
    end
    repeat (300) step();

    guard = 0;
    while (!ovr_done && guard < 2000) begin step(); guard++; end
    check("ovr_bench_done", 32'(ovr_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
